// File: rtl/montgomery_mult_if.sv
// Start/done handshake bundle for montgomery_mult: operands in, result and status out.
interface montgomery_mult_if #(
  parameter int WIDTH = 4096
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] N;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
  logic             err;

  modport master (
    output start, A, B, N,
    input  result, done, busy, err
  );

  modport slave (
    input  start, A, B, N,
    output result, done, busy, err
  );
endinterface

// File: rtl/montgomery_mult.sv
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod N, one bit of A per cycle.
// Optional operand range check compiled in with MONT_MULT_OPERAND_CHECK_EN.
module montgomery_mult #(
  parameter int WIDTH = 4096
) (
  input  logic              clk,
  input  logic              rst,
  montgomery_mult_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam int SW    = WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FINAL = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [SW-1:0]    s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [SW-1:0]    b_ext;
  logic [SW-1:0]    n_ext;
  logic [SW-1:0]    t_add;
  logic [SW-1:0]    t_red;
  logic [WIDTH-1:0] s_final;

`ifdef MONT_MULT_OPERAND_CHECK_EN
  logic err_q, err_d;
  logic bad_q, bad_d;
  logic operands_bad;
  assign operands_bad = ~bus.N[0] | (bus.A >= bus.N) | (bus.B >= bus.N);
`endif

  // One Montgomery step: add B when the current A bit is set, add N to make the sum even, halve.
  assign b_ext   = {2'b00, b_q};
  assign n_ext   = {2'b00, n_q};
  assign t_add   = s_q + (a_q[0] ? b_ext : '0);
  assign t_red   = t_add[0] ? (t_add + n_ext) : t_add;
  // S < 2N, so the corrected value is below N and fits in WIDTH bits after truncation.
  assign s_final = (s_q >= n_ext) ? (s_q[WIDTH-1:0] - n_q) : s_q[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    n_d      = n_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
`ifdef MONT_MULT_OPERAND_CHECK_EN
    err_d    = err_q;
    bad_d    = bad_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d    = bus.A;
          b_d    = bus.B;
          n_d    = bus.N;
          s_d    = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
          state_d = ITER;
`ifdef MONT_MULT_OPERAND_CHECK_EN
          err_d = 1'b0;
          bad_d = operands_bad;
          if (operands_bad) begin
            state_d = FINAL;
          end
`endif
        end
      end
      ITER: begin
        s_d   = t_red >> 1;
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        result_d = s_final;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
`ifdef MONT_MULT_OPERAND_CHECK_EN
        if (bad_q) begin
          result_d = '0;
          err_d    = 1'b1;
        end else begin
          err_d    = 1'b0;
        end
        bad_d = 1'b0;
`endif
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      s_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MONT_MULT_OPERAND_CHECK_EN
      err_q    <= 1'b0;
      bad_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      n_q      <= n_d;
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef MONT_MULT_OPERAND_CHECK_EN
      err_q    <= err_d;
      bad_q    <= bad_d;
`endif
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
`ifdef MONT_MULT_OPERAND_CHECK_EN
  assign bus.err    = err_q;
`else
  assign bus.err    = 1'b0;
`endif
endmodule

// File: tb/tb_montgomery_mult.sv
// Self-checking bench for montgomery_mult at WIDTH=8 (R=256): vector table, random ops vs model, handshake corners.
module tb_montgomery_mult;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  montgomery_mult_if #(.WIDTH(W)) bus ();

  montgomery_mult #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int exp;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // a*b*R^-1 mod n found by searching for x with x*R == a*b (mod n).
  function automatic int ref_mont(input int a, input int b, input int n);
    int p;
    p = (a * b) % n;
    for (int x = 0; x < n; x++) begin
      if (((x * 256) % n) == p) return x;
    end
    return -1;
  endfunction

  // Runs one operation; lat is the edge number of the done pulse (-1 if none within budget).
  task automatic do_op(input int a, input int b, input int n,
                       output int res, output int lat, output int busy_bad, output int err_v);
    @(negedge clk);
    bus.A = W'(a); bus.B = W'(b); bus.N = W'(n); bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A = W'($urandom); bus.B = W'($urandom); bus.N = W'($urandom);
    res = -1; lat = -1; busy_bad = 0; err_v = -1;
    if (!bus.busy) busy_bad++;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = e; res = int'(bus.result); err_v = int'(bus.err);
        break;
      end
      if (!bus.busy) busy_bad++;
    end
    if (lat > 0) begin
      chk("busy_low_at_done", int'(bus.busy), 0);
      @(posedge clk); #1;
      chk("done_one_cycle", int'(bus.done), 0);
    end
  endtask

  initial begin
    int res, lat, bb, ev, n, a, b, dones;
    int de[$];

    vecs[0] = '{a: 1,   b: 1,   exp: 225};
    vecs[1] = '{a: 5,   b: 50,  exp: 85};
    vecs[2] = '{a: 17,  b: 5,   exp: 5};
    vecs[3] = '{a: 238, b: 238, exp: 225};
    vecs[4] = '{a: 0,   b: 200, exp: 0};

    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.N = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", int'(bus.result), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_err", int'(bus.err), 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      do_op(vecs[i].a, vecs[i].b, 239, res, lat, bb, ev);
      $display("vec %0d: A=%0d B=%0d N=239 result=%0d exp=%0d done_edge=%0d", i, vecs[i].a, vecs[i].b, res, vecs[i].exp, lat);
      chk("vec_result", res, vecs[i].exp);
      chk("vec_latency", lat, W + 1);
      chk("vec_busy", bb, 0);
      chk("vec_err", ev, 0);
    end

    for (int i = 0; i < 20; i++) begin
      n = 2 * $urandom_range(1, 127) + 1;
      a = $urandom_range(0, n - 1);
      b = $urandom_range(0, n - 1);
      do_op(a, b, n, res, lat, bb, ev);
      $display("rand %0d: A=%0d B=%0d N=%0d result=%0d exp=%0d", i, a, b, n, res, ref_mont(a, b, n));
      chk("rand_result", res, ref_mont(a, b, n));
      chk("rand_latency", lat, W + 1);
    end

    // start pulsed on edges 3 and 9 while busy must be ignored.
    @(negedge clk);
    bus.A = 8'd3; bus.B = 8'd7; bus.N = 8'd239; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    dones = 0; lat = -1;
    for (int e = 1; e <= 30; e++) begin
      if (e == 3 || e == 9) begin @(negedge clk); bus.start = 1'b1; end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) begin dones++; if (lat < 0) lat = e; res = int'(bus.result); end
    end
    $display("ignore-start: dones=%0d first_edge=%0d result=%0d", dones, lat, res);
    chk("ignore_start_dones", dones, 1);
    chk("ignore_start_edge", lat, 9);
    chk("ignore_start_result", res, ref_mont(3, 7, 239));

    // start held high: second done comes WIDTH+2 cycles after the first.
    @(negedge clk);
    bus.A = 8'd9; bus.B = 8'd11; bus.N = 8'd239; bus.start = 1'b1;
    @(posedge clk); #1;
    de.delete();
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (bus.done) begin de.push_back(e); res = int'(bus.result); end
      if (e == 19) bus.start = 1'b0;
    end
    $display("held-start: dones=%0d result=%0d", de.size(), res);
    chk("held_start_count", de.size(), 2);
    if (de.size() == 2) begin
      chk("held_start_first", de[0], 9);
      chk("held_start_second", de[1], 19);
    end
    chk("held_start_result", res, ref_mont(9, 11, 239));

    // Reset on edge 5 discards the operation.
    @(negedge clk);
    bus.A = 8'd100; bus.B = 8'd120; bus.N = 8'd239; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    dones = 0;
    for (int e = 1; e <= 20; e++) begin
      if (e == 5) begin @(negedge clk); rst = 1'b1; end
      @(posedge clk); #1;
      if (e == 5) begin
        rst = 1'b0;
        chk("midrst_result", int'(bus.result), 0);
        chk("midrst_busy", int'(bus.busy), 0);
      end
      if (bus.done) dones++;
    end
    $display("mid-reset: dones=%0d", dones);
    chk("midrst_no_done", dones, 0);
    do_op(100, 120, 239, res, lat, bb, ev);
    $display("after-reset: result=%0d exp=%0d done_edge=%0d", res, ref_mont(100, 120, 239), lat);
    chk("after_rst_result", res, ref_mont(100, 120, 239));
    chk("after_rst_latency", lat, W + 1);

    // rst and start on the same edge: start dropped.
    @(negedge clk);
    bus.A = 8'd1; bus.B = 8'd1; bus.N = 8'd239; bus.start = 1'b1; rst = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0; rst = 1'b0;
    dones = 0; bb = 0;
    for (int e = 1; e <= 15; e++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
      if (bus.busy) bb++;
    end
    $display("rst+start: dones=%0d busy_cycles=%0d", dones, bb);
    chk("rst_start_done", dones, 0);
    chk("rst_start_busy", bb, 0);

`ifdef MONT_MULT_OPERAND_CHECK_EN
    do_op(5, 7, 238, res, lat, bb, ev);
    $display("check even N: result=%0d err=%0d done_edge=%0d", res, ev, lat);
    chk("chk_evenN_latency", lat, 1);
    chk("chk_evenN_err", ev, 1);
    chk("chk_evenN_result", res, 0);
    chk("chk_err_held", int'(bus.err), 1);
    do_op(239, 5, 239, res, lat, bb, ev);
    $display("check A>=N: result=%0d err=%0d", res, ev);
    chk("chk_AgeN_err", ev, 1);
    chk("chk_AgeN_result", res, 0);
    do_op(5, 50, 239, res, lat, bb, ev);
    $display("check valid: result=%0d err=%0d", res, ev);
    chk("chk_valid_err", ev, 0);
    chk("chk_valid_result", res, 85);
`else
    do_op(5, 7, 238, res, lat, bb, ev);
    $display("unchecked even N: err=%0d done_edge=%0d", ev, lat);
    chk("nochk_err", ev, 0);
    chk("nochk_latency", lat, W + 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
